// File: rtl/mem_stage_ctrl.sv
// Memory-stage access controller: issues data-memory requests, stalls the
// pipeline while an access is outstanding, and latches halt / error / timeout.
module mem_stage_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_enable_EM,
  input  logic        mem_write_en_EM,
  input  logic        dump_EM,
  input  logic        mem_done,
  input  logic        mem_err,
  output logic        mem_req,
  output logic        mem_wr,
  output logic        stall_pipe,
  output logic        bubble_MW,
  output logic        halt_out,
  output logic        err_out,
  output logic [15:0] access_cnt,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, HALT, ERR} state_t;

  state_t     state_q, state_d;
  logic [7:0] wait_cnt;
  logic       count_access, wait_clr, wait_inc;

  // Strobes are forced low while rst is held, even though state is already IDLE.
  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    stall_pipe   = 1'b0;
    bubble_MW    = 1'b0;
    count_access = 1'b0;
    wait_clr     = 1'b0;
    wait_inc     = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (dump_EM) begin
            state_d = HALT;
          end else if (mem_enable_EM) begin
            mem_req = 1'b1;
            mem_wr  = mem_write_en_EM;
            if (mem_done && !mem_err) begin
              count_access = 1'b1;
            end else if (mem_done) begin
              stall_pipe = 1'b1;
              bubble_MW  = 1'b1;
              state_d    = ERR;
            end else begin
              stall_pipe = 1'b1;
              bubble_MW  = 1'b1;
              wait_clr   = 1'b1;
              state_d    = WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_done && !mem_err) begin
            count_access = 1'b1;
            state_d      = IDLE;
          end else begin
            stall_pipe = 1'b1;
            bubble_MW  = 1'b1;
            // completion on the last allowed cycle is handled above and wins
            if (mem_done || wait_cnt == 8'hFF) state_d  = ERR;
            else                               wait_inc = 1'b1;
          end
        end
        default: begin
          stall_pipe = 1'b1;
          bubble_MW  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt   <= '0;
      access_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      state_q <= state_d;
      if (wait_clr)                                 wait_cnt   <= '0;
      else if (wait_inc)                            wait_cnt   <= wait_cnt + 8'd1;
      if (count_access)                             access_cnt <= access_cnt + 16'd1;
      if (stall_pipe && stall_cnt != 16'hFFFF)      stall_cnt  <= stall_cnt + 16'd1;
    end
  end

  assign halt_out = (state_q == HALT);
  assign err_out  = (state_q == ERR);

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: mem_enable_EM  input  1  EX/MEM register output; instruction needs data memory.
REQ-004 SHALL have port: mem_write_en_EM  input  1  EX/MEM register output; access is a store.
REQ-005 SHALL have port: dump_EM  input  1  EX/MEM register output; HALT instruction in memory stage.
REQ-006 SHALL have port: mem_done  input  1  data memory completed current access (load data valid / store committed).
REQ-007 SHALL have port: mem_err  input  1  data memory error; meaningful only with mem_done.
REQ-008 SHALL have port: mem_req  output  1  one-cycle access start to data memory.
REQ-009 SHALL have port: mem_wr  output  1  store qualifier; equals mem_write_en_EM while mem_req=1, else 0.
REQ-010 SHALL have port: stall_pipe  output  1  hold enable for PC, IF/ID, ID/EX, EX/MEM registers.
REQ-011 SHALL have port: bubble_MW  output  1  forces MEM/WB control bits (reg_write_en, dump) to 0.
REQ-012 SHALL have port: halt_out  output  1  processor halted.
REQ-013 SHALL have port: err_out  output  1  sticky memory error / timeout.
REQ-014 SHALL have port: access_cnt  output  16  completed accesses, wraps 0xFFFF->0x0000.
REQ-015 SHALL have port: stall_cnt  output  16  stalled cycles, saturates at 0xFFFF.

Function
REQ-016 SHALL implement states IDLE, WAIT, HALT, ERR (registered); mem_req, mem_wr, stall_pipe, bubble_MW decoded combinationally from state and inputs.
REQ-017 IDLE, mem_enable_EM=1, dump_EM=0: mem_req=1 that cycle; if mem_done=1 same cycle (hit) -> no stall, stay IDLE; else stall_pipe=1, bubble_MW=1, -> WAIT.
REQ-018 IDLE, mem_enable_EM=0, dump_EM=0: all strobes 0, stay IDLE.
REQ-019 IDLE, dump_EM=1: mem_req=0 regardless of mem_enable_EM; -> HALT next edge; stall_pipe=0 that cycle so HALT's own MEM/WB entry is captured.
REQ-020 WAIT: mem_req=0; mem_done=0 -> stall_pipe=1, bubble_MW=1, stay WAIT; mem_done=1, mem_err=0 -> stall_pipe=0, bubble_MW=0 (result captured), -> IDLE.
REQ-021 mem_done=1 with mem_err=1 (IDLE or WAIT) -> ERR next edge; stall_pipe=1, bubble_MW=1 that cycle.
REQ-022 8-bit wait counter: cleared on IDLE->WAIT, +1 per WAIT cycle without mem_done; WAIT with counter=255 and mem_done=0 -> ERR.
REQ-023 mem_done in WAIT on same cycle counter=255: completion wins, -> IDLE.
REQ-024 HALT: stall_pipe=1, bubble_MW=1, halt_out=1, mem_req=0; exits only on rst.
REQ-025 ERR: stall_pipe=1, bubble_MW=1, err_out=1, mem_req=0; exits only on rst.
REQ-026 mem_done outside a requesting IDLE cycle or WAIT SHALL be ignored.
REQ-027 access_cnt +1 on every cycle mem_done=1 and mem_err=0 in requesting IDLE or WAIT.
REQ-028 stall_cnt +1 on every cycle stall_pipe=1, holding at 0xFFFF.
REQ-029 Back-to-back: a completion cycle followed by new mem_enable_EM SHALL issue mem_req on the very next cycle (no dead cycle).

Reset
REQ-030 rst=1 asynchronously: state=IDLE, wait counter=0, access_cnt=0, stall_cnt=0, halt_out=0, err_out=0.
REQ-031 During rst=1, mem_req, mem_wr, stall_pipe, bubble_MW SHALL be 0 irrespective of inputs.
REQ-032 rst asserted in WAIT abandons access; after release, first mem_enable_EM issues fresh mem_req.

Verification
REQ-033 Hit load: IDLE, mem_enable_EM=1, mem_done=1 same cycle -> mem_req=1, mem_wr=0, stall_pipe=0, access_cnt 0->1.
REQ-034 3-cycle store: mem_enable_EM=1, mem_write_en_EM=1, mem_done on 3rd cycle -> mem_req 1 cycle, mem_wr=1 with it, stall_pipe=1 for 2 cycles, stall_cnt=2, access_cnt=1.
REQ-035 Timeout: request, mem_done never -> ERR after 256 WAIT cycles, err_out=1, stall_pipe stays 1; mem_done at WAIT cycle 256 instead -> IDLE, no error.
REQ-036 Error: mem_done=1, mem_err=1 in WAIT -> ERR, access_cnt unchanged, err_out=1 until rst.
REQ-037 Halt: dump_EM=1 with mem_enable_EM=1 -> mem_req=0, halt_out=1 next cycle, stall_pipe=1 thereafter.
REQ-038 Reset mid-WAIT: rst pulse during WAIT -> all outputs 0 immediately, counters 0, next request issues mem_req.
